// File: rtl/mem_responder.sv
// Word-organised memory responder with valid/ready request and response channels,
// programmable wait states, byte-enable writes and misaligned/out-of-range error flagging.
module mem_responder #(
    parameter int DEPTH       = 128,
    parameter int AW          = 7,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_be_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    logic [31:0] mem [DEPTH];

    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          rsp_err_q, rsp_err_d;

    logic          we_q;
    logic [AW-1:0] idx_q;
    logic [31:0]   wdata_q;
    logic [3:0]    be_q;
    logic          err_q;

    logic          accept;
    logic          req_err;
    logic          access;
    logic          acc_we;
    logic          acc_err;
    logic [AW-1:0] acc_idx;
    logic [31:0]   acc_wdata;
    logic [3:0]    acc_be;

    assign req_ready_o = (state_q == ST_IDLE) && !rst;
    assign accept      = req_valid_i && req_ready_o;
    assign req_err     = (req_addr_i[1:0] != 2'b00) ||
                         ({2'b00, req_addr_i[31:2]} >= 32'(DEPTH));

    // With zero wait states the access happens on the accept edge, so use the live request.
    always_comb begin
        acc_we    = we_q;
        acc_err   = err_q;
        acc_idx   = idx_q;
        acc_wdata = wdata_q;
        acc_be    = be_q;
        if (state_q == ST_IDLE) begin
            acc_we    = req_we_i;
            acc_err   = req_err;
            acc_idx   = req_addr_i[AW+1:2];
            acc_wdata = req_wdata_i;
            acc_be    = req_be_i;
        end
    end

    assign access = (accept && (WAIT_CYCLES == 0)) ||
                    ((state_q == ST_WAIT) && (cnt_q == 4'd0) && !rst);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;
        rsp_err_d = rsp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_INIT;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (access) begin
            rdata_d   = acc_err ? 32'd0 : mem[acc_idx];
            rsp_err_d = acc_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            rdata_q   <= 32'd0;
            rsp_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
            rsp_err_q <= rsp_err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= req_we_i;
            idx_q   <= req_addr_i[AW+1:2];
            wdata_q <= req_wdata_i;
            be_q    <= req_be_i;
            err_q   <= req_err;
        end
    end

    // Memory is deliberately left out of reset so its contents survive rst.
    always_ff @(posedge clk) begin
        if (access && acc_we && !acc_err) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_be[b]) begin
                    mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
                end
            end
        end
    end

    assign rsp_valid_o = (state_q == ST_RESP);
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = rsp_err_q;

endmodule
